// File: rtl/conv_pe_acc_pkg.sv
// Shared sizes, pipeline sideband type and the tap-masking rule for the conv PE.
package conv_pe_acc_pkg;
    localparam int K          = 3;
    localparam int Tin        = 4;
    localparam int Tout       = 4;
    localparam int W_DATA     = 8;
    localparam int W_KERNEL   = 8;
    localparam int W_PSUM     = 20;
    localparam int W_ACC      = 32;
    localparam int MAX_COLS   = 256;
    localparam int W_COL      = $clog2(MAX_COLS);
    localparam int PE_DELAY   = 5;
    localparam int NTAP       = K * K;
    localparam int W_PROD     = W_DATA + W_KERNEL;
    localparam int W_LIDX     = $clog2(Tin);
    localparam int W_IFM_COL  = K * Tin * W_DATA;
    localparam int W_FILT     = NTAP * W_KERNEL;
    localparam int W_LANE_IFM = Tin * NTAP * W_DATA;
    localparam int W_LANE_WGT = Tin * NTAP * W_KERNEL;

    // Per-window sideband that rides alongside the datapath stages.
    typedef struct packed {
        logic             first;
        logic             last;
        logic [W_COL-1:0] col;
    } meta_t;

    // 1 if tap (row r, column k) contributes; 1x1 keeps only the centre tap.
    function automatic logic tap_keep(input int r, input int k, input logic mode_1x1,
                                      input logic fr, input logic lr,
                                      input logic fc, input logic lc);
        if (mode_1x1) return (r == K / 2) && (k == K / 2);
        return !((fr && r == 0) || (lr && r == K - 1) || (fc && k == 0) || (lc && k == K - 1));
    endfunction
endpackage

// File: rtl/conv_pe_acc_dot.sv
// One output lane: Tin x 9 signed MAC with a registered adder tree (S2..S4).
module pe_dot_tin
    import conv_pe_acc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  vld_in,
    input  logic [W_LANE_IFM-1:0] ifm,
    input  logic [W_LANE_WGT-1:0] wgt,
    output logic                  vld_out,
    output logic [W_PSUM-1:0]     psum
);
    logic [3:1]                       vld_pipe;
    logic [Tin*NTAP-1:0][W_PROD-1:0]  prod_d, prod_q;
    logic [Tin-1:0][W_PSUM-1:0]       csum_d, csum_q;
    logic [W_PSUM-1:0]                psum_d, psum_q;

    // Signed element products; 8x8 always fits 16 bits exactly.
    always_comb begin
        prod_d = '0;
        for (int i = 0; i < Tin * NTAP; i++)
            prod_d[i] = $signed(ifm[i*W_DATA +: W_DATA]) * $signed(wgt[i*W_KERNEL +: W_KERNEL]);
    end

    // Per-channel tap sums from S2, lane sum from S3; both wrap at W_PSUM.
    always_comb begin
        csum_d = '0;
        psum_d = '0;
        for (int c = 0; c < Tin; c++)
            for (int t = 0; t < NTAP; t++)
                csum_d[c] = csum_d[c] + {{(W_PSUM-W_PROD){prod_q[c*NTAP+t][W_PROD-1]}},
                                         prod_q[c*NTAP+t]};
        for (int c = 0; c < Tin; c++)
            psum_d = psum_d + csum_q[c];
    end

    // Pipeline registers S2/S3/S4 with matching valid shift register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
            prod_q   <= '0;
            csum_q   <= '0;
            psum_q   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[2:1], vld_in};
            prod_q   <= prod_d;
            csum_q   <= csum_d;
            psum_q   <= psum_d;
        end
    end

    assign vld_out = vld_pipe[3];
    assign psum    = psum_q;
endmodule

// File: rtl/conv_pe_acc.sv
// Conv PE: sliding window, double-buffered filters, masking (S1), per-lane dot
// products (S2..S4) and per-column input-tile accumulation (S5).
module conv_pe_acc
    import conv_pe_acc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    c_ctrl_data_run,
    input  logic                    c_top_cal_start,
    input  logic                    c_is_first_row,
    input  logic                    c_is_last_row,
    input  logic                    c_is_first_col,
    input  logic                    c_is_last_col,
    input  logic                    c_mode_1x1,
    input  logic                    c_acc_first,
    input  logic                    c_acc_last,
    input  logic [W_COL-1:0]        c_col,
    input  logic [W_IFM_COL-1:0]    bm_ifm_data_flat,
    input  logic                    load_filter,
    input  logic [W_LIDX-1:0]       load_idx,
    input  logic [Tout*W_FILT-1:0]  bm_filter_data_flat,
    input  logic                    change_filter,
    output logic [Tout*W_ACC-1:0]   o_acc,
    output logic                    o_vld,
    output logic [W_COL-1:0]        o_col
);
    logic [Tin*W_DATA-1:0]          win [K][K];   // win[row][col], col 0 oldest
    logic [W_FILT-1:0]              shadow [Tin*Tout];
    logic [W_FILT-1:0]              active [Tin*Tout];
    logic [W_LANE_IFM-1:0]          ifm_mask, s1_ifm;
    logic [Tout-1:0][W_LANE_WGT-1:0] wgt_lane, s1_wgt;
    logic                           s1_vld;
    meta_t                          meta_pipe [1:4];
    meta_t                          m4;
    logic [Tout-1:0]                dot_vld;
    logic [Tout-1:0][W_PSUM-1:0]    psum;
    logic                           s4_vld;
    logic [Tout-1:0][W_ACC-1:0]     acc_sum;
    logic [Tout-1:0][W_ACC-1:0]     mem [MAX_COLS];

    // Window shift: data_run loads a new column, a bare cal_start holds the last one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < K; r++)
                for (int k = 0; k < K; k++) win[r][k] <= '0;
        end else if (c_ctrl_data_run || c_top_cal_start) begin
            for (int r = 0; r < K; r++) begin
                for (int k = 0; k < K - 1; k++) win[r][k] <= win[r][k+1];
                if (c_ctrl_data_run)
                    win[r][K-1] <= bm_ifm_data_flat[r*Tin*W_DATA +: Tin*W_DATA];
            end
        end
    end

    // Filter banks; on a same-cycle load+swap the active bank takes the pre-load shadow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < Tin * Tout; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (change_filter)
                for (int i = 0; i < Tin * Tout; i++) active[i] <= shadow[i];
            if (load_filter)
                for (int o = 0; o < Tout; o++)
                    shadow[Tin*o + int'(load_idx)] <= bm_filter_data_flat[o*W_FILT +: W_FILT];
        end
    end

    // Padding / 1x1 masking, regrouped channel-major to match the lane layout.
    always_comb begin
        ifm_mask = '0;
        for (int c = 0; c < Tin; c++)
            for (int r = 0; r < K; r++)
                for (int k = 0; k < K; k++)
                    if (tap_keep(r, k, c_mode_1x1, c_is_first_row, c_is_last_row,
                                 c_is_first_col, c_is_last_col))
                        ifm_mask[(c*NTAP + r*K + k)*W_DATA +: W_DATA] = win[r][k][c*W_DATA +: W_DATA];
    end

    // Gather each lane's Tin filters from the active bank.
    always_comb begin
        wgt_lane = '0;
        for (int o = 0; o < Tout; o++)
            for (int c = 0; c < Tin; c++)
                for (int t = 0; t < NTAP; t++)
                    wgt_lane[o][(c*NTAP + t)*W_KERNEL +: W_KERNEL] = active[Tin*o + c][t*W_KERNEL +: W_KERNEL];
    end

    // S1 operand registers and the sideband pipe kept in lockstep with S1..S4.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld <= 1'b0;
            s1_ifm <= '0;
            s1_wgt <= '0;
            for (int s = 1; s <= 4; s++) meta_pipe[s] <= '0;
        end else begin
            s1_vld <= c_top_cal_start;
            if (c_top_cal_start) begin
                s1_ifm <= ifm_mask;
                s1_wgt <= wgt_lane;
            end
            meta_pipe[1] <= {c_acc_first, c_acc_last, c_col};
            for (int s = 2; s <= 4; s++) meta_pipe[s] <= meta_pipe[s-1];
        end
    end

    for (genvar o = 0; o < Tout; o++) begin : g_lane
        pe_dot_tin u_dot (
            .clk     (clk),
            .rstn    (rstn),
            .vld_in  (s1_vld),
            .ifm     (s1_ifm),
            .wgt     (s1_wgt[o]),
            .vld_out (dot_vld[o]),
            .psum    (psum[o])
        );
    end

    assign s4_vld = &dot_vld;
    assign m4     = meta_pipe[4];

    // S5 accumulate: async mem read so a back-to-back issue sees the prior write.
    always_comb begin
        acc_sum = '0;
        for (int o = 0; o < Tout; o++)
            acc_sum[o] = (m4.first ? '0 : mem[m4.col][o])
                       + {{(W_ACC-W_PSUM){psum[o][W_PSUM-1]}}, psum[o]};
    end

    // Psum store is intentionally unreset; acc_first defines each column.
    always_ff @(posedge clk) begin
        if (s4_vld) mem[m4.col] <= acc_sum;
    end

    // Output register, loaded only on the last input-channel tile.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_vld <= 1'b0;
            o_acc <= '0;
            o_col <= '0;
        end else begin
            o_vld <= s4_vld && m4.last;
            if (s4_vld && m4.last) begin
                o_acc <= acc_sum;
                o_col <= m4.col;
            end
        end
    end
endmodule

// File: doc/conv_pe_acc.md
# conv_pe_acc

Parametrised 3x3/1x1 convolution processing element with built-in input-channel-tile accumulation. It holds a K-column sliding IFM window (Tin channels per pixel) and a double-buffered Tin×Tout filter bank. It computes Tout partial sums per window in a fixed 5-cycle pipeline and accumulates them across input-channel tiles in a per-column psum store. Fully accumulated Tout outputs are emitted on the last tile. It sits between the buffer manager (IFM/filter buffers) and the post-processing (bias/quant/activation) stage.

## Interface
- K, 3, kernel size (fixed 3; 1x1 is a runtime mode)
- Tin, 4, input channels per tile
- Tout, 4, output channels per tile
- W_DATA, 8, IFM element width, signed
- W_KERNEL, 8, weight width, signed
- W_PSUM, 20, per-window tile psum width
- W_ACC, 32, accumulated output width
- MAX_COLS, 256, max output columns in a row
- W_COL, $clog2(MAX_COLS), column index width
- clk  in  1  clock
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- c_ctrl_data_run  in  1  shift window, load new column
- c_top_cal_start  in  1  issue one window computation
- c_is_first_row / c_is_last_row / c_is_first_col / c_is_last_col  in  1 each  padding flags, sampled with cal_start
- c_mode_1x1  in  1  1 = pointwise mode
- c_acc_first / c_acc_last  in  1 each  first/last input-channel tile, sampled with cal_start
- c_col  in  W_COL  output column index, sampled with cal_start
- bm_ifm_data_flat  in  K*Tin*W_DATA  one column: row r at [r*Tin*W_DATA +: Tin*W_DATA], channel c at byte c
- load_filter  in  1  write shadow filter bank
- load_idx  in  $clog2(Tin)  shadow slot within each Tout group
- bm_filter_data_flat  in  Tout*K*K*W_KERNEL  Tout filters, tap t at [t*W_KERNEL]
- change_filter  in  1  copy shadow bank to active bank
- o_acc  out  Tout*W_ACC  accumulated outputs, lane o at [o*W_ACC +: W_ACC]
- o_vld  out  1  o_acc/o_col valid (one cycle)
- o_col  out  W_COL  column of o_acc

## Operation
- Window: K×K registers of Tin×W_DATA. data_run: all columns shift left; column K-1 takes the input. cal_start without data_run: shift left; column K-1 holds.
- Padding (3x3): taps in row 0 are zeroed on first_row; row 2 on last_row; column 0 on first_col; column 2 on last_col.
- 1x1 mode: only the center tap (row 1, col 1) contributes. The other 8 products are forced to 0. Padding flags are ignored.
- Filters: load_filter writes shadow[Tin*o+load_idx] = filter o of bm_filter_data_flat, for all o. change_filter copies shadow to active. If both are asserted in the same cycle, active receives the pre-load shadow.
- psum[o] = Σ over c<Tin and t<9 of ifm[c][t]*w[Tin*o+c][t]. Products are signed 16-bit, sign-extended, and summed at W_PSUM. The sum wraps.
- Accumulate stage: acc = acc_first ? sext(psum) : mem[col][o] + sext(psum), wrapping at W_ACC, no saturation. The result is written back to mem[col][o]. If acc_last, o_acc = acc, o_col = col, o_vld = 1.
- acc_first and acc_last may both be 1 (single tile).
- Flags and col travel with the pipeline. The filter used is the active bank in the cal_start cycle.

## Timing
- Pipeline: S1 masked window and weights registered. S2 products. S3 per-channel 9-tap sums. S4 Tin-lane psum. S5 accumulate plus output register.
- cal_start in cycle N gives o_vld in cycle N+5 (PE_DELAY=5). Throughput is 1 window per cycle.
- mem has asynchronous read and synchronous write in S5. The same col may be issued on consecutive cycles; the second issue sees the first issue's write.
- Reset: window, both filter banks, pipeline valids and o_acc/o_vld/o_col are cleared to 0. mem is not reset; it is defined by acc_first.
- A reset mid-pipeline drops all in-flight windows, with no o_vld.
- mem entries for a column are undefined until written with acc_first.
- If c_col ≥ MAX_COLS the behaviour is undefined; the controller guarantees the range.

## Structure
- controller_params.vh: add W_ACC, MAX_COLS, W_COL, PE_DELAY=5. Tin, Tout, K, W_DATA, W_KERNEL and W_PSUM are already defined there.
- Sub-module pe_dot_tin, one instance per Tout lane: Tin×9 signed MAC plus adder tree, pipeline stages S2–S4, 3 cycles, vld in to vld out.
- The top level holds the window, filter banks, masking, psum mem and accumulate stage.

## Test plan
- 3x3 single tile, all IFM=1, all weights=1, interior pixel, acc_first=acc_last=1 → o_acc lanes = 36 at N+5, o_col echoes c_col.
- Corner padding: first_row and first_col set, same data → o_acc = 16. last_row and last_col set → 16.
- 1x1 mode: center tap=3, others=7, center weight=−2, others=5, Tin=4 → o_acc = −24.
- Three tiles on col 5 with psums 10, −3, 100 (first, mid, last) → single o_vld with o_acc = 107. Interleave col 6 back-to-back and check there is no cross-talk.
- Load a new shadow bank while computing with change_filter asserted in the same cycle as load_filter → the old shadow becomes active. Windows issued before change_filter use the old weights.
- Assert rstn low 2 cycles after cal_start → no o_vld; all outputs 0. The next computation after reset is correct.
